// File: rtl/tt_sub_pkg.sv
// Shared constants for the bit-serial 6-bit subtractor: FSM encoding,
// default operand width and the Tiny Tapeout pin map.
package tt_sub_pkg;

    // Operand width fixed by the pin budget (legal range 1..6)
    localparam int DEF_WIDTH = 6;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Pin indices on ui_in / uo_out
    localparam int START_BIT = 7;
    localparam int BIN_BIT   = 6;
    localparam int DONE_BIT  = 7;
    localparam int BOUT_BIT  = 6;

    // Bit-index counter width: clog2(width), never below 1
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bw_in, with borrow out.
module serial_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);

    // Difference bit and borrow propagation for one bit position
    always_comb begin
        d      = a ^ b ^ bw_in;
        bw_out = (~a & b) | (~(a ^ b) & bw_in);
    end

endmodule

// File: rtl/tt_um_6bitsub_serial.sv
// Bit-serial subtractor, Tiny Tapeout user module. Operands are captured on
// START, processed LSB-first one bit per clock, and the result is held with
// DONE until START is released. All uo_out bits come straight from flops.
module tt_um_6bitsub_serial
    import tt_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             bw_q, bw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic             start;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bw;
    logic [WIDTH-1:0] sh_next;

    // ena is always 1 when powered; uio_in[7:6] carry nothing
    logic unused_pins;
    assign unused_pins = &{1'b0, ena, uio_in[7:6]};

    assign start    = ui_in[START_BIT];
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    serial_sub_cell u_cell (
        .a      (a_q[cnt_q]),
        .b      (b_q[cnt_q]),
        .bw_in  (bw_q),
        .d      (cell_d),
        .bw_out (cell_bw)
    );

    // New difference bit enters at the MSB so bit 0 lands at index 0 after WIDTH shifts
    assign sh_next = (sh_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values together.
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)    state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  if (!start)   state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // Datapath next values: capture in IDLE, one bit per edge in RUN, release in DONE
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        bw_d   = bw_q;
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        d_d    = d_q;
        bout_d = bout_q;
        done_d = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d   = ui_in[WIDTH-1:0];
                    b_d   = uio_in[WIDTH-1:0];
                    bw_d  = ui_in[BIN_BIT];
                    cnt_d = '0;
                    sh_d  = '0;
                end
            end
            S_RUN: begin
                sh_d  = sh_next;
                bw_d  = cell_bw;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    d_d    = sh_next;
                    bout_d = cell_bw;
                    done_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            S_DONE: begin
                if (!start) done_d = 1'b0;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears any partial result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every register is reset here, including the result, so an aborted run leaves nothing visible.
            a_q    <= '0;
            b_q    <= '0;
            bw_q   <= 1'b0;
            cnt_q  <= '0;
            sh_q   <= '0;
            d_q    <= '0;
            bout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            bw_q   <= bw_d;
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            d_q    <= d_d;
            bout_q <= bout_d;
            done_q <= done_d;
        end
    end

    // Output pin map; unused high difference bits read 0
    always_comb begin
        uo_out           = '0;
        uo_out[5:0]      = 6'(d_q);
        uo_out[BOUT_BIT] = bout_q;
        uo_out[DONE_BIT] = done_q;
        uio_out          = '0;
        uio_oe           = '0;
    end

endmodule

// File: tb/tb_tt_um_6bitsub_serial.sv
// Directed and random checks for the bit-serial 6-bit subtractor.
module tb_tt_um_6bitsub_serial;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int         n_checks;
    int         n_fails;
    logic [6:0] prev_res;

    tt_um_6bitsub_serial dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Arithmetic contract: {BOUT,D} = (A - B - BIN) mod 128, DONE set
    function automatic logic [7:0] model(input logic [5:0] a, input logic [5:0] b, input logic bin);
        logic [6:0] r;
        r = {1'b0, a} - {1'b0, b} - {6'd0, bin};
        return {1'b1, r};
    endfunction

    // Start an operation at a falling edge and wait for DONE with START held.
    // cyc counts falling edges after the request: capture edge + 6 RUN edges -> 7.
    task automatic do_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                         input logic bin, input bit scramble, input logic [7:0] exp_uo);
        int  cyc;
        bit  seen;
        @(negedge clk);
        ui_in  = {1'b1, bin, a};
        uio_in = {2'b00, b};
        seen   = 1'b0;
        cyc    = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (uo_out[7]) begin
                seen = 1'b1;
                cyc  = i;
            end else if (i == 3) begin
                check({tag, "_hold_prev"}, 32'(uo_out), 32'({1'b0, prev_res}));
            end
            if (scramble && !seen) begin
                ui_in  = {1'b1, 7'($urandom)};
                uio_in = 8'($urandom);
            end
        end
        check({tag, "_latency"}, 32'(cyc), 32'd7);
        check({tag, "_uo"}, 32'(uo_out), 32'(exp_uo));
        check({tag, "_uio"}, 32'({uio_oe, uio_out}), 32'd0);
        prev_res = exp_uo[6:0];
    endtask

    // Release START while in DONE: DONE clears on the next edge, result stays
    task automatic drop_start(input string tag);
        ui_in[7] = 1'b0;
        @(negedge clk);
        check({tag, "_release"}, 32'(uo_out), 32'({1'b0, prev_res}));
    endtask

    initial begin
        logic [5:0] ra, rb;
        logic       rbin;
        bit         dropped;

        n_checks = 0;
        n_fails  = 0;
        prev_res = '0;
        ena      = 1'b1;
        ui_in    = '0;
        uio_in   = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_uo", 32'(uo_out), 32'h00);
        check("reset_uio", 32'({uio_oe, uio_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_uo", 32'(uo_out), 32'h00);

        // 20 - 5 = 15, then hold START for 20 cycles: no retrigger, DONE stays
        do_op("sub20_5", 6'd20, 6'd5, 1'b0, 1'b0, 8'h8F);
        dropped = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uo_out !== 8'h8F) dropped = 1'b1;
        end
        check("hold_start_stable", 32'(dropped), 32'd0);
        drop_start("sub20_5");

        // 5 - 20 wraps with borrow out
        do_op("sub5_20", 6'd5, 6'd20, 1'b0, 1'b0, 8'hF1);
        drop_start("sub5_20");

        // 0 - 0 - 1: borrow-in ripples through every bit
        do_op("sub0_0_b", 6'd0, 6'd0, 1'b1, 1'b0, 8'hFF);
        drop_start("sub0_0_b");

        // 63 - 63 with inputs scrambled during RUN
        do_op("sub63_63", 6'd63, 6'd63, 1'b0, 1'b1, 8'h80);
        drop_start("sub63_63");

        // Async reset in the middle of RUN
        @(negedge clk);
        ui_in  = {1'b1, 1'b0, 6'd33};
        uio_in = 8'd12;
        repeat (4) @(negedge clk);
        ui_in[7] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_uo", 32'(uo_out), 32'h00);
        @(negedge clk);
        rst_n    = 1'b1;
        prev_res = '0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", 32'(uo_out), 32'h00);
        do_op("sub10_3", 6'd10, 6'd3, 1'b0, 1'b0, 8'h87);
        drop_start("sub10_3");

        // Random sweep against the arithmetic contract
        for (int n = 0; n < 1000; n++) begin
            ra   = 6'($urandom_range(0, 63));
            rb   = 6'($urandom_range(0, 63));
            rbin = 1'($urandom_range(0, 1));
            do_op("rand", ra, rb, rbin, (n % 4) == 0, model(ra, rb, rbin));
            drop_start("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
